// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB3 bridge for a single APB slave.
// Each AHB NONSEQ/SEQ transfer becomes one APB SETUP+ACCESS sequence, with the AHB data phase stretched until PREADY.
module ahb2apb_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  HRESETn,
    input  logic                  HSELAHB,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADY,
    output logic                  HRESP,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    // state  | meaning
    // IDLE   | no APB activity, ready for a new AHB transfer
    // WWAIT  | write address latched, waiting for HWDATA in the AHB data phase
    // SETUP  | APB setup phase (PSEL=1, PENABLE=0)
    // ACCESS | APB access phase, held until PREADY
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WWAIT,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  pwrite_q, pwrite_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  xfer_valid;

    // BUSY and IDLE differ from NONSEQ/SEQ only in HTRANS[1]
    logic unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    assign HREADY     = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && PREADY);
    assign xfer_valid = HSELAHB && HREADY && HTRANS[1];
    assign HRESP      = 1'b0;
    assign HRDATA     = ((state_q == ST_ACCESS) && !pwrite_q) ? PRDATA : '0;

    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;

    always_comb begin
        state_d  = state_q;
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        pwdata_d = pwdata_q;
        case (state_q)
            // HREADY is low only in ACCESS with PREADY=0, where everything holds
            ST_IDLE, ST_ACCESS: begin
                if (HREADY) begin
                    if (xfer_valid) begin
                        paddr_d  = HADDR;
                        pwrite_d = HWRITE;
                        state_d  = HWRITE ? ST_WWAIT : ST_SETUP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WWAIT: begin
                pwdata_d = HWDATA;
                state_d  = ST_SETUP;
            end
            ST_SETUP: state_d = ST_ACCESS;
            default:  state_d = ST_IDLE;
        endcase
        psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        penable_d = (state_d == ST_ACCESS);
    end

    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: vector table of single transfers, APB scoreboard,
// plus hand-written back-to-back, ignored-traffic and mid-access reset sequences.
module tb_ahb2apb_bridge;

    logic        clk = 1'b0;
    logic        HRESETn;
    logic        HSELAHB;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic        PREADY;
    logic [31:0] PRDATA;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb2apb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .HRESETn(HRESETn), .HSELAHB(HSELAHB), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(PREADY),
        .PRDATA(PRDATA)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int          waits;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // APB side: every completed access must match the oldest expected transfer
    always @(negedge clk) begin
        exp_t e;
        if (HRESETn === 1'b1 && PSEL === 1'b1 && PENABLE === 1'b1 && PREADY === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL apb_unexpected actual=%0h required=none", PADDR);
            end else begin
                e = sb.pop_front();
                check("apb_paddr", 64'(PADDR), 64'(e.addr));
                check("apb_pwrite", 64'(PWRITE), 64'(e.write));
                if (e.write) check("apb_pwdata", 64'(PWDATA), 64'(e.wdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1 in IDLE; returns at posedge+1 after the transfer completed.
    task automatic xfer(input vec_t v);
        int  lows, cyc, acc, setup_cyc;
        bit  done;
        HSELAHB = 1'b1;
        HTRANS  = 2'b10;
        HADDR   = v.addr;
        HWRITE  = v.write;
        PRDATA  = v.prdata;
        PREADY  = 1'b1;
        sb.push_back('{addr: v.addr, write: v.write, wdata: v.wdata});
        @(negedge clk);
        check("addr_phase_hready", 64'(HREADY), 64'd1);
        @(posedge clk); #1;
        HSELAHB = 1'b0;
        HTRANS  = 2'b00;
        HADDR   = $urandom;
        HWDATA  = v.wdata;
        lows = 0; cyc = 1; acc = 0; setup_cyc = -1; done = 0;
        while (!done && cyc < 30) begin
            if (cyc >= 2) HWDATA = ~v.wdata;
            if (PSEL && !PENABLE && setup_cyc < 0) setup_cyc = cyc;
            PREADY = !(PSEL && PENABLE) || (acc >= v.waits);
            if (PSEL && PENABLE) acc++;
            @(negedge clk);
            if (PSEL && PENABLE) begin
                check("access_paddr_stable", 64'(PADDR), 64'(v.addr));
                check("access_pwrite_stable", 64'(PWRITE), 64'(v.write));
            end
            if (HREADY) begin
                done = 1;
                if (!v.write) check("hrdata", 64'(HRDATA), 64'(v.prdata));
            end else begin
                lows++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) check("xfer_timeout", 64'd0, 64'd1);
        check("hready_low_cycles", 64'(lows), 64'((v.write ? 2 : 1) + v.waits));
        check("setup_cycle", 64'(setup_cyc), 64'(v.write ? 2 : 1));
        check("idle_psel", 64'(PSEL), 64'd0);
    endtask

    vec_t vecs[6];
    logic [31:0] last_addr;

    initial begin
        logic [1:0] ign_trans[4];
        logic       ign_sel[4];

        vecs[0] = '{write: 1'b1, addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF, prdata: 32'h0,          waits: 0};
        vecs[1] = '{write: 1'b0, addr: 32'h0000_0020, wdata: 32'h0,          prdata: 32'h1234_5678, waits: 0};
        vecs[2] = '{write: 1'b0, addr: 32'h0000_0024, wdata: 32'h0,          prdata: 32'hA5A5_F00F, waits: 3};
        vecs[3] = '{write: 1'b1, addr: 32'h0000_0030, wdata: 32'h0102_0304, prdata: 32'h0,          waits: 2};
        vecs[4] = '{write: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0,          prdata: 32'hFFFF_FFFF, waits: 1};
        vecs[5] = '{write: 1'b1, addr: 32'hFFFF_FFF0, wdata: 32'h0000_0001, prdata: 32'h0,          waits: 0};
        ign_sel[0] = 1'b1; ign_trans[0] = 2'b00;
        ign_sel[1] = 1'b1; ign_trans[1] = 2'b01;
        ign_sel[2] = 1'b0; ign_trans[2] = 2'b10;
        ign_sel[3] = 1'b0; ign_trans[3] = 2'b11;

        HRESETn = 1'b0; HSELAHB = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HWDATA = '0; PREADY = 1'b1; PRDATA = '0;
        #12;
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_hready", 64'(HREADY), 64'd1);
        check("rst_hresp", 64'(HRESP), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        check("rst_hrdata", 64'(HRDATA), 64'd0);
        @(posedge clk); #1;
        HRESETn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) xfer(vecs[i]);
        last_addr = vecs[5].addr;

        for (int i = 0; i < 4; i++) begin
            HSELAHB = ign_sel[i];
            HTRANS  = ign_trans[i];
            HADDR   = $urandom;
            HWRITE  = i[0];
            @(negedge clk);
            check("ign_hready", 64'(HREADY), 64'd1);
            check("ign_hresp", 64'(HRESP), 64'd0);
            @(posedge clk); #1;
            check("ign_psel", 64'(PSEL), 64'd0);
            check("ign_paddr_hold", 64'(PADDR), 64'(last_addr));
        end
        HSELAHB = 1'b0; HTRANS = 2'b00;

        // back-to-back: write 0x40, read 0x44 presented in the write's completing ACCESS cycle
        PREADY = 1'b1;
        HSELAHB = 1'b1; HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1'b1;
        sb.push_back('{addr: 32'h40, write: 1'b1, wdata: 32'hCAFE_0001});
        @(posedge clk); #1;
        HSELAHB = 1'b0; HTRANS = 2'b00; HWDATA = 32'hCAFE_0001;
        @(posedge clk); #1;
        check("b2b_w_setup", 64'({PSEL, PENABLE}), 64'b10);
        @(posedge clk); #1;
        check("b2b_w_access", 64'({PSEL, PENABLE}), 64'b11);
        HSELAHB = 1'b1; HTRANS = 2'b10; HADDR = 32'h44; HWRITE = 1'b0; PRDATA = 32'h55AA_55AA;
        sb.push_back('{addr: 32'h44, write: 1'b0, wdata: 32'h0});
        @(negedge clk);
        check("b2b_w_hready", 64'(HREADY), 64'd1);
        @(posedge clk); #1;
        HSELAHB = 1'b0; HTRANS = 2'b00;
        check("b2b_r_setup", 64'({PSEL, PENABLE}), 64'b10);
        check("b2b_r_paddr", 64'(PADDR), 64'h44);
        @(negedge clk);
        check("b2b_r_setup_hready", 64'(HREADY), 64'd0);
        @(posedge clk); #1;
        check("b2b_r_access", 64'({PSEL, PENABLE}), 64'b11);
        @(negedge clk);
        check("b2b_r_hrdata", 64'(HRDATA), 64'h55AA_55AA);
        @(posedge clk); #1;
        check("b2b_idle", 64'({PSEL, PENABLE}), 64'b00);

        // reset while an access is stalled
        HSELAHB = 1'b1; HTRANS = 2'b10; HADDR = 32'h80; HWRITE = 1'b0; PRDATA = 32'h7777_7777;
        sb.push_back('{addr: 32'h80, write: 1'b0, wdata: 32'h0});
        @(posedge clk); #1;
        HSELAHB = 1'b0; HTRANS = 2'b00;
        @(posedge clk); #1;
        PREADY = 1'b0;
        check("mid_access", 64'({PSEL, PENABLE}), 64'b11);
        #2;
        HRESETn = 1'b0;
        #1;
        check("mid_rst_psel", 64'(PSEL), 64'd0);
        check("mid_rst_penable", 64'(PENABLE), 64'd0);
        check("mid_rst_hready", 64'(HREADY), 64'd1);
        check("mid_rst_hresp", 64'(HRESP), 64'd0);
        check("mid_rst_paddr", 64'(PADDR), 64'd0);
        check("mid_rst_pwdata", 64'(PWDATA), 64'd0);
        check("mid_rst_hrdata", 64'(HRDATA), 64'd0);
        void'(sb.pop_back());
        @(posedge clk); #1;
        HRESETn = 1'b1;
        PREADY = 1'b1;
        @(posedge clk); #1;
        check("post_rst_psel", 64'(PSEL), 64'd0);
        @(posedge clk); #1;
        check("post_rst_psel2", 64'(PSEL), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb2apb_bridge.md
Name: ahb2apb_bridge

Overview:
Single-slave AHB-Lite to APB (APB3, with PREADY) bridge. It accepts AHB NONSEQ/SEQ transfers, registers the address and control, and replays each transfer as one APB SETUP+ACCESS sequence. It stretches the AHB data phase with HREADY low until the APB access completes. It sits between the AHB interconnect (HSELAHB decode) and one APB peripheral.

Parameters:
ADDR_WIDTH, 32, width of HADDR/PADDR
DATA_WIDTH, 32, width of HWDATA/HRDATA/PWDATA/PRDATA

Ports:
clk  input  1  bridge clock (HCLK = PCLK)
HRESETn  input  1  reset, asynchronous, active-low
HSELAHB  input  1  bridge selected by AHB decoder
HADDR  input  ADDR_WIDTH  AHB address
HTRANS  input  2  AHB transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
HWRITE  input  1  1 = write, 0 = read
HWDATA  input  DATA_WIDTH  AHB write data, valid in the data phase
HRDATA  output  DATA_WIDTH  AHB read data
HREADY  output  1  transfer done / bridge ready
HRESP  output  1  response; always 0 (OKAY)
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PADDR  output  ADDR_WIDTH  APB address
PWRITE  output  1  APB direction
PWDATA  output  DATA_WIDTH  APB write data
PREADY  input  1  APB slave ready
PRDATA  input  DATA_WIDTH  APB read data

Behaviour:
- Interface: one clock, clk. Reset HRESETn is asynchronous and active-low.
- Valid transfer = HSELAHB & HREADY & HTRANS[1]. IDLE and BUSY transfers, and any transfer with HSELAHB=0, are ignored with an OKAY/zero-wait response.
- FSM states: IDLE, WWAIT, SETUP, ACCESS. All P* outputs are registered.
- IDLE: HREADY=1. On a valid transfer, at the clock edge:
  - latch HADDR into PADDR and HWRITE into PWRITE;
  - go to WWAIT if write, SETUP if read.
- WWAIT (write only): HREADY=0. At the edge, capture HWDATA into PWDATA and go to SETUP.
- SETUP: PSEL=1, PENABLE=0, HREADY=0. Unconditionally go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=0: stay in ACCESS, HREADY=0, all P* signals held stable.
  - PREADY=1: HREADY=1 (combinational) and the transfer completes. At the edge, if a new valid transfer is presented in this cycle, latch it and go to WWAIT or SETUP. Otherwise go to IDLE and drop PSEL/PENABLE to 0.
- HRDATA = PRDATA while in ACCESS with PWRITE=0; 0 otherwise.
- HREADY is a combinational decode of the state and PREADY. While HREADY=0, AHB address/control inputs are not sampled.
- Latency with PREADY=1: read data phase = 2 cycles (1 wait state); write data phase = 3 cycles (2 wait states). Each PREADY=0 cycle adds 1.
- HRESP is constant 0. PSLVERR is not supported.
- PADDR, PWRITE and PWDATA hold their last values in IDLE.
- Reset (asynchronous, any state, including mid-access): state=IDLE, PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0. HREADY then reads 1, HRDATA 0, HRESP 0. No partial APB transfer resumes after reset.

Test Plan:
1. Reset: assert HRESETn=0 during ACCESS -> PSEL/PENABLE=0 immediately; HREADY=1, HRESP=0, PADDR=0, PWDATA=0.
2. Single write: HADDR=0x0000_0010, HTRANS=10, HWRITE=1, then HWDATA=0xDEAD_BEEF, PREADY=1 -> PSEL rises 2 cycles after the address phase with PADDR=0x10, PWDATA=0xDEADBEEF, PWRITE=1; PENABLE follows 1 cycle later; HREADY low for exactly 2 cycles.
3. Single read: HADDR=0x20, HWRITE=0, PRDATA=0x1234_5678, PREADY=1 -> SETUP on the next cycle, then ACCESS; HREADY low 1 cycle; HRDATA=0x12345678 in the HREADY=1 cycle.
4. APB wait states: read with PREADY=0 for 3 ACCESS cycles -> PSEL/PENABLE/PADDR stable, HREADY low 4 cycles, HRDATA valid only when PREADY=1.
5. Back-to-back: write 0x40 then read 0x44, the second address presented during the first ACCESS completion -> no IDLE gap; the second SETUP directly follows the first ACCESS.
6. Ignored traffic: HTRANS=00/01 or HSELAHB=0 with random HADDR -> PSEL stays 0, HREADY=1, HRESP=0.
